load_store_unit: RTL

//  Sits directly downstream of the datapath ALU and replaces its ideal data_memory.

---
 rtl/load_store_unit_pkg.sv | 51 +++++
 rtl/load_store_unit_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 decode and byte-lane helpers for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_LH, F3_LHU: return lo[0];
      F3_LW:         return lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic store);
    case (funct3)
      F3_LB, F3_LH, F3_LW: return 1'b0;
      F3_LBU, F3_LHU:      return store;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] lo);
    case (mem_size_e'(funct3[1:0]))
      SIZE_B:  return 4'b0001 << lo;
      SIZE_H:  return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] funct3, input logic [31:0] wd);
    case (mem_size_e'(funct3[1:0]))
      SIZE_B:  return {4{wd[7:0]}};
      SIZE_H:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed lane of a bus read word and sign/zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sign_ext;

  assign shifted  = rdata >> {lane, 3'b000};
  assign sign_ext = ~funct3[2];

  always_comb begin
    data = rdata;
    case (mem_size_e'(funct3[1:0]))
      SIZE_B:  data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_H:  data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: req/gnt/rvalid data-bus master that stalls the core until the access completes.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              access_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_e        state, next_state;
  logic              op, fault, launch;
  logic [1:0]        lane;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] aligned;

  assign op    = mem_read | mem_write;
  assign fault = is_illegal(funct3, mem_write) | is_misaligned(funct3, addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    stall        = 1'b0;
    access_fault = 1'b0;
    launch       = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          if (fault) begin
            access_fault = 1'b1;
          end else begin
            stall      = 1'b1;
            launch     = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt) next_state = bus_we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured once at launch so they stay stable until gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      lane      <= '0;
      funct3_q  <= '0;
    end else if (launch) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_write;
      bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
      bus_be    <= byte_enable(funct3, addr[1:0]);
      bus_wdata <= lane_replicate(funct3, write_data);
      lane      <= addr[1:0];
      funct3_q  <= funct3;
    end else if (state == REQ && bus_gnt) begin
      bus_req   <= 1'b0;
    end
  end

  load_align u_load_align (
    .rdata  (bus_rdata),
    .lane   (lane),
    .funct3 (funct3_q),
    .data   (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               load_data <= '0;
    else if (state == WAIT && bus_rvalid)  load_data <= aligned;
  end

endmodule
